k423_pipe_stage_buf: RTL
========================

// Module: k423_pipe_stage_buf
// PURPOSE
//  Generic, parametrised inter-stage pipeline buffer for the k423 core. Supersedes per-stage hand-written regs (ex->wb etc.).
//  Carries an opaque DATA_W payload through a DEPTH-entry elastic FIFO with valid/ready handshake on both sides.
//  Supports stage stall, branch flush and optional combinational ready pass-through (DEPTH=1 acts as a classic pipe reg).
//  Sits between any two stages; payload is a packed struct from k423_pipe_pkg.
// PARAMETERS
//  DATA_W        32  payload width in bits (>=1)
//  DEPTH         2   buffer entries (>=1, need not be a power of 2)
//  PASSTHRU_RDY  1   1: up_rdy_o also asserted when full and dn side dequeues this cycle
//  ZERO_ON_FLUSH 1   1: storage cleared to 0 on flush; 0: storage keeps stale data
// PORTS
//  clk_i      in   1                      clock, rising edge
//  rst_i      in   1                      asynchronous reset, active-high
//  flush_i    in   1                      branch flush (pcu_flush_br), drop all entries
//  stall_i    in   1                      downstream stall (pcu_stall_*), blocks dequeue
//  up_vld_i   in   1                      upstream stage valid
//  up_rdy_o   out  1                      buffer can accept
//  up_data_i  in   DATA_W                 upstream payload
//  dn_vld_o   out  1                      head entry valid to downstream
//  dn_rdy_i   in   1                      downstream ready
//  dn_data_o  out  DATA_W                 head payload
//  count_o    out  $clog2(DEPTH+1)        occupied entries
// BEHAVIOUR
//  - Reset (rst_i=1, async): wr_ptr=rd_ptr=0, count=0, all storage=0; dn_vld_o=0, dn_data_o=0, count_o=0, up_rdy_o=1.
//  - enq = up_vld_i & up_rdy_o & ~flush_i; deq = dn_vld_o & dn_rdy_i.
//  - dn_vld_o = (count!=0) & ~stall_i & ~flush_i; dn_data_o = mem[rd_ptr] always (undefined-free: 0 after reset/flush if ZERO_ON_FLUSH).
//  - up_rdy_o = (count!=DEPTH) | (PASSTHRU_RDY & dn_rdy_i & ~stall_i & (count!=0)). Does not depend on up_vld_i.
//  - Latency: enq in cycle N -> earliest dn_vld_o in cycle N+1 (no combinational data bypass). Throughput 1/cycle at any DEPTH when PASSTHRU_RDY=1, or DEPTH>=2.
//  - Pointers: increment on enq/deq, wrap from DEPTH-1 to 0 explicitly. count += enq - deq.
//  - Full & enq & deq same cycle: count unchanged, write slot = slot being read (wr_ptr==rd_ptr); new data visible next cycle.
//  - Empty & enq & stall: entry stored, dn_vld_o stays 0 until stall_i drops.
//  - stall_i: no dequeue, enqueue continues until full; count never exceeds DEPTH.
//  - flush_i (sync, highest priority after reset): next cycle count=0, ptrs=0, dn_vld_o=0; same-cycle enq discarded,
//    same-cycle deq suppressed (dn_vld_o=0). Storage zeroed iff ZERO_ON_FLUSH. flush & stall together = flush.
//  - Reset mid-transfer: all entries lost, no partial state; outputs at reset values while rst_i=1.
//  - up_vld_i while ~up_rdy_o: payload ignored, no state change (upstream must hold).
//  - Assertions: count<=DEPTH; never deq when count==0; never enq when count==DEPTH & ~deq.
// STRUCTURE
//  - k423_pipe_pkg: typedef struct packed ex2wb_payload_t {pc, rd_vld, rd_idx, rd, rd_load, load_size,
//    load_unsigned, load_addr, br_tkn, br_pc} using CORE_ADDR_W/CORE_XLEN/INST_RSDIDX_W/RSD_SIZE_W; likewise
//    if2id/id2ex payload structs; localparam widths via $bits(...). Stage wrappers instantiate this block with DATA_W=$bits(t).
//  - One sub-module k423_pipe_buf_ctrl: pointer/count/full/empty logic parametrised by DEPTH (no data path);
//    storage array and output mux stay in the top.
// TESTING
//  T1 reset: rst_i=1 mid-traffic with count=2 -> dn_vld_o=0, count_o=0, up_rdy_o=1, dn_data_o=0 immediately (async).
//  T2 streaming DEPTH=2: up_vld_i=1 every cycle, data 0x1,0x2,...,0x10, dn_rdy_i=1 -> dn sees 0x1..0x10 in order,
//     first at cycle+1, one per cycle, count_o stays 1.
//  T3 fill/backpressure DEPTH=3: dn_rdy_i=0, push 0xA,0xB,0xC,0xD -> up_rdy_o=0 after 3rd; 0xD held upstream;
//     dn_rdy_i=1 -> out 0xA,0xB,0xC,0xD; pointers wrap 2->0 with no loss.
//  T4 full+simultaneous DEPTH=1 PASSTHRU_RDY=1: full with 0x5, dn_rdy_i=1, up 0x6 same cycle -> enq accepted,
//     next cycle dn_data_o=0x6, count_o=1; repeat with PASSTHRU_RDY=0 -> up_rdy_o=0, enq refused.
//  T5 flush: count=2 (0x11,0x22), flush_i=1 with up_vld_i=1 (0x33) -> dn_vld_o=0 that cycle, next cycle count_o=0,
//     dn_data_o=0 (ZERO_ON_FLUSH=1); 0x33 never appears downstream.
//  T6 stall: count=1, stall_i=1 for 3 cycles with dn_rdy_i=1 and up pushing -> dn_vld_o=0, count rises to DEPTH
//     then up_rdy_o=0; stall_i=0 -> drain in original order.

Source files
------------

// File: rtl/k423_pipe_pkg.sv
// k423 pipeline payload types and shared helpers for the inter-stage buffers.
package k423_pipe_pkg;

  localparam int CORE_ADDR_W   = 32;
  localparam int CORE_XLEN     = 32;
  localparam int INST_RSDIDX_W = 5;
  localparam int RSD_SIZE_W    = 2;
  localparam int INST_W        = 32;

  typedef struct packed {
    logic [CORE_ADDR_W-1:0] pc;
    logic [INST_W-1:0]      inst;
  } if2id_payload_t;

  typedef struct packed {
    logic [CORE_ADDR_W-1:0]   pc;
    logic [INST_W-1:0]        inst;
    logic                     rd_vld;
    logic [INST_RSDIDX_W-1:0] rd_idx;
    logic [CORE_XLEN-1:0]     rs1_val;
    logic [CORE_XLEN-1:0]     rs2_val;
    logic [CORE_XLEN-1:0]     imm;
  } id2ex_payload_t;

  typedef struct packed {
    logic [CORE_ADDR_W-1:0]   pc;
    logic                     rd_vld;
    logic [INST_RSDIDX_W-1:0] rd_idx;
    logic [CORE_XLEN-1:0]     rd;
    logic                     rd_load;
    logic [RSD_SIZE_W-1:0]    load_size;
    logic                     load_unsigned;
    logic [CORE_ADDR_W-1:0]   load_addr;
    logic                     br_tkn;
    logic [CORE_ADDR_W-1:0]   br_pc;
  } ex2wb_payload_t;

  localparam int IF2ID_W = $bits(if2id_payload_t);
  localparam int ID2EX_W = $bits(id2ex_payload_t);
  localparam int EX2WB_W = $bits(ex2wb_payload_t);

  // Pointer width for a buffer of the given depth; a single-entry buffer still
  // gets a one-bit pointer so that every vector has a legal width.
  function automatic int buf_ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/k423_pipe_buf_ctrl.sv
// Pointer, occupancy and handshake control for the k423 pipeline buffer (no data path).
module k423_pipe_buf_ctrl
  import k423_pipe_pkg::*;
#(
  parameter int DEPTH        = 2,
  parameter bit PASSTHRU_RDY = 1'b1,
  parameter int PTR_W        = buf_ptr_w(DEPTH),
  parameter int CNT_W        = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             stall,
  input  logic             up_vld,
  input  logic             dn_rdy,
  output logic             up_rdy,
  output logic             dn_vld,
  output logic             enq,
  output logic             deq,
  output logic [PTR_W-1:0] wr_ptr,
  output logic [PTR_W-1:0] rd_ptr,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  logic empty;
  logic full;

  assign empty  = (count == CNT_W'(0));
  assign full   = (count == FULL_CNT);
  // Head is only offered when neither a stall nor a flush is pending.
  assign dn_vld = ~empty & ~stall & ~flush;
  // Ready never looks at up_vld; the pass-through term lets a full buffer
  // accept when the head is leaving in the same cycle.
  assign up_rdy = ~full | (PASSTHRU_RDY & dn_rdy & ~stall & ~empty);
  assign enq    = up_vld & up_rdy & ~flush;
  assign deq    = dn_vld & dn_rdy;

  // Pointer and occupancy state: flush clears everything, otherwise move on enq/deq.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= PTR_W'(0);
      rd_ptr <= PTR_W'(0);
      count  <= CNT_W'(0);
    end else if (flush) begin
      wr_ptr <= PTR_W'(0);
      rd_ptr <= PTR_W'(0);
      count  <= CNT_W'(0);
    end else begin
      if (enq) begin
        wr_ptr <= (wr_ptr == LAST_PTR) ? PTR_W'(0) : wr_ptr + PTR_W'(1);
      end else begin
        wr_ptr <= wr_ptr;
      end
      if (deq) begin
        rd_ptr <= (rd_ptr == LAST_PTR) ? PTR_W'(0) : rd_ptr + PTR_W'(1);
      end else begin
        rd_ptr <= rd_ptr;
      end
      case ({enq, deq})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/k423_pipe_stage_buf_chk.sv
// Protocol checker for k423_pipe_stage_buf: occupancy bounds and legal enq/deq.
module k423_pipe_stage_buf_chk #(
  parameter int DEPTH = 2
) (
  input logic                         clk,
  input logic                         rst,
  input logic                         flush,
  input logic                         up_vld,
  input logic                         up_rdy,
  input logic                         dn_vld,
  input logic                         dn_rdy,
  input logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic enq;
  logic deq;

  assign enq = up_vld & up_rdy & ~flush;
  assign deq = dn_vld & dn_rdy;

  a_count_bound: assert property (@(posedge clk) disable iff (rst) count <= FULL_CNT);
  a_no_deq_empty: assert property (@(posedge clk) disable iff (rst) deq |-> (count != CNT_W'(0)));
  a_no_enq_full: assert property (@(posedge clk) disable iff (rst) (enq && count == FULL_CNT) |-> deq);

endmodule

// File: rtl/k423_pipe_stage_buf.sv
// Generic k423 inter-stage elastic buffer: DEPTH-entry FIFO with valid/ready on both sides.
module k423_pipe_stage_buf
  import k423_pipe_pkg::*;
#(
  parameter int DATA_W        = 32,
  parameter int DEPTH         = 2,
  parameter bit PASSTHRU_RDY  = 1'b1,
  parameter bit ZERO_ON_FLUSH = 1'b1
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic                       stall_i,
  input  logic                       up_vld_i,
  output logic                       up_rdy_o,
  input  logic [DATA_W-1:0]          up_data_i,
  output logic                       dn_vld_o,
  input  logic                       dn_rdy_i,
  output logic [DATA_W-1:0]          dn_data_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int PTR_W = buf_ptr_w(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              enq;
  logic              deq;
  logic [DATA_W-1:0] head;

  k423_pipe_buf_ctrl #(
    .DEPTH        (DEPTH),
    .PASSTHRU_RDY (PASSTHRU_RDY),
    .PTR_W        (PTR_W),
    .CNT_W        (CNT_W)
  ) u_ctrl (
    .clk    (clk_i),
    .rst    (rst_i),
    .flush  (flush_i),
    .stall  (stall_i),
    .up_vld (up_vld_i),
    .dn_rdy (dn_rdy_i),
    .up_rdy (up_rdy_o),
    .dn_vld (dn_vld_o),
    .enq    (enq),
    .deq    (deq),
    .wr_ptr (wr_ptr),
    .rd_ptr (rd_ptr),
    .count  (count)
  );

  // Storage: cleared on reset (and on flush when configured), written at wr_ptr on enq.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= DATA_W'(0);
      end
    end else if (flush_i && ZERO_ON_FLUSH) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= DATA_W'(0);
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (enq && (wr_ptr == PTR_W'(i))) begin
          mem[i] <= up_data_i;
        end else begin
          mem[i] <= mem[i];
        end
      end
    end
  end

  // Head mux: the slot at rd_ptr is always presented, even when empty.
  always_comb begin
    head = DATA_W'(0);
    for (int i = 0; i < DEPTH; i++) begin
      head = (rd_ptr == PTR_W'(i)) ? mem[i] : head;
    end
  end

  assign dn_data_o = head;
  assign count_o   = count;

endmodule
